// File: rtl/sc_lane_shift_bank.sv
// sc_lane_shift_bank
// Background lane register bank for the Frogger playfield. Each lane holds one
// row pattern that rotates on its own programmable period and direction. The
// game FSM can clear all lanes, preload them from a per-level table, write a
// single lane, reprogram a lane's period/direction and pause all motion. The
// video driver reads the packed lane data and the per-lane shift strobes; the
// frog collision logic reads a single cell through the probe.
//
// Ports
//   SC_RegBACKGTYPE_CLOCK_50       system clock, rising edge
//   SC_RegBACKGTYPE_RESET_InHigh   asynchronous reset, active high
//   SC_RegBACKGTYPE_clear_InLow    clear all lane data (active low)
//   SC_RegBACKGTYPE_load_InLow     preload all lanes from LEVEL_INIT (active low)
//   SC_RegBACKGTYPE_level_In       level select for load
//   SC_RegBACKGTYPE_write_InLow    write lane_In with data_InBUS (active low)
//   SC_RegBACKGTYPE_lane_In        lane addressed by write/cfg
//   SC_RegBACKGTYPE_data_InBUS     write data
//   SC_RegBACKGTYPE_cfg_InLow      write period/dir of lane_In (active low)
//   SC_RegBACKGTYPE_period_InBUS   shift period in clocks, 0 = lane stopped
//   SC_RegBACKGTYPE_dir_In         0 = rotate left, 1 = rotate right
//   SC_RegBACKGTYPE_pause_InHigh   freeze all automatic shifting
//   SC_RegBACKGTYPE_probeLane_In   probe lane
//   SC_RegBACKGTYPE_probeCol_In    probe column
//   SC_RegBACKGTYPE_data_OutBUS    packed lanes, lane k at [k*DATAWIDTH +: DATAWIDTH]
//   SC_RegBACKGTYPE_strobe_OutBUS  per-lane pulse in the cycle shifted data appears
//   SC_RegBACKGTYPE_probe_Out      lane[probeLane][probeCol], 0 when out of range

module sc_lane_shift_bank #(
   parameter int DATAWIDTH  = 8,
   parameter int LANES      = 4,
   parameter int LANE_IDX_W = 2,
   parameter int COL_W      = 3,
   parameter int PRESCALE_W = 8,
   parameter logic [4*LANES*DATAWIDTH-1:0] LEVEL_INIT =
      128'h0F0F0F0F_81818181_3C3C3C3C_18181818
) (
   input  logic                        SC_RegBACKGTYPE_CLOCK_50,
   input  logic                        SC_RegBACKGTYPE_RESET_InHigh,
   input  logic                        SC_RegBACKGTYPE_clear_InLow,
   input  logic                        SC_RegBACKGTYPE_load_InLow,
   input  logic [1:0]                  SC_RegBACKGTYPE_level_In,
   input  logic                        SC_RegBACKGTYPE_write_InLow,
   input  logic [LANE_IDX_W-1:0]       SC_RegBACKGTYPE_lane_In,
   input  logic [DATAWIDTH-1:0]        SC_RegBACKGTYPE_data_InBUS,
   input  logic                        SC_RegBACKGTYPE_cfg_InLow,
   input  logic [PRESCALE_W-1:0]       SC_RegBACKGTYPE_period_InBUS,
   input  logic                        SC_RegBACKGTYPE_dir_In,
   input  logic                        SC_RegBACKGTYPE_pause_InHigh,
   input  logic [LANE_IDX_W-1:0]       SC_RegBACKGTYPE_probeLane_In,
   input  logic [COL_W-1:0]            SC_RegBACKGTYPE_probeCol_In,
   output logic [LANES*DATAWIDTH-1:0]  SC_RegBACKGTYPE_data_OutBUS,
   output logic [LANES-1:0]            SC_RegBACKGTYPE_strobe_OutBUS,
   output logic                        SC_RegBACKGTYPE_probe_Out
);

   logic [DATAWIDTH-1:0]  lane_q   [LANES];
   logic [DATAWIDTH-1:0]  lane_d   [LANES];
   logic [PRESCALE_W-1:0] period_q [LANES];
   logic [PRESCALE_W-1:0] cnt_q    [LANES];
   logic [PRESCALE_W-1:0] cnt_d    [LANES];
   logic [LANES-1:0]      dir_q;
   logic [LANES-1:0]      strobe_q;
   logic [LANES-1:0]      write_hit;
   logic [LANES-1:0]      cfg_hit;
   logic [LANES-1:0]      restart;
   logic [LANES-1:0]      running;
   logic [LANES-1:0]      tick;

   logic clear, load, write, cfg;

   assign clear = ~SC_RegBACKGTYPE_clear_InLow;
   assign load  = ~SC_RegBACKGTYPE_load_InLow;
   assign write = ~SC_RegBACKGTYPE_write_InLow;
   assign cfg   = ~SC_RegBACKGTYPE_cfg_InLow;

   always_comb begin
      for (int k = 0; k < LANES; k++) begin
         // Lane addresses at or beyond LANES never match, so such writes/cfgs drop out.
         write_hit[k] = write && (SC_RegBACKGTYPE_lane_In == LANE_IDX_W'(k));
         cfg_hit[k]   = cfg   && (SC_RegBACKGTYPE_lane_In == LANE_IDX_W'(k));
         restart[k]   = clear || load || write_hit[k] || cfg_hit[k];
         running[k]   = !SC_RegBACKGTYPE_pause_InHigh && (period_q[k] != '0);
         tick[k]      = running[k] && !restart[k] &&
                        (cnt_q[k] == period_q[k] - PRESCALE_W'(1));

         if (restart[k])
            cnt_d[k] = '0;
         else if (!running[k])
            cnt_d[k] = cnt_q[k];
         else if (tick[k])
            cnt_d[k] = '0;
         else
            cnt_d[k] = cnt_q[k] + PRESCALE_W'(1);

         if (clear)
            lane_d[k] = '0;
         else if (load)
            lane_d[k] = LEVEL_INIT[(int'(SC_RegBACKGTYPE_level_In) * LANES + k) * DATAWIDTH +: DATAWIDTH];
         else if (write_hit[k])
            lane_d[k] = SC_RegBACKGTYPE_data_InBUS;
         else if (tick[k])
            lane_d[k] = dir_q[k] ? {lane_q[k][0], lane_q[k][DATAWIDTH-1:1]}
                                 : {lane_q[k][DATAWIDTH-2:0], lane_q[k][DATAWIDTH-1]};
         else
            lane_d[k] = lane_q[k];
      end
   end

   always_ff @(posedge SC_RegBACKGTYPE_CLOCK_50 or posedge SC_RegBACKGTYPE_RESET_InHigh) begin
      if (SC_RegBACKGTYPE_RESET_InHigh) begin
         for (int k = 0; k < LANES; k++) begin
            lane_q[k]   <= '0;
            period_q[k] <= '0;
            cnt_q[k]    <= '0;
         end
         dir_q    <= '0;
         strobe_q <= '0;
      end else begin
         for (int k = 0; k < LANES; k++) begin
            lane_q[k] <= lane_d[k];
            cnt_q[k]  <= cnt_d[k];
            if (cfg_hit[k]) begin
               period_q[k] <= SC_RegBACKGTYPE_period_InBUS;
               dir_q[k]    <= SC_RegBACKGTYPE_dir_In;
            end
         end
         // A tick is already suppressed by clear/load/write, so the strobe follows it directly.
         strobe_q <= tick;
      end
   end

   always_comb begin
      for (int k = 0; k < LANES; k++)
         SC_RegBACKGTYPE_data_OutBUS[k*DATAWIDTH +: DATAWIDTH] = lane_q[k];
   end

   assign SC_RegBACKGTYPE_strobe_OutBUS = strobe_q;

   // Decoded by exhaustive match so out-of-range lane/column selects read 0.
   always_comb begin
      SC_RegBACKGTYPE_probe_Out = 1'b0;
      for (int k = 0; k < LANES; k++)
         for (int c = 0; c < DATAWIDTH; c++)
            if (SC_RegBACKGTYPE_probeLane_In == LANE_IDX_W'(k) &&
                SC_RegBACKGTYPE_probeCol_In == COL_W'(c))
               SC_RegBACKGTYPE_probe_Out = lane_q[k][c];
   end

endmodule

// File: tb/tb_sc_lane_shift_bank.sv
// Bench for sc_lane_shift_bank built with 3-bit lane and 4-bit column selects
// so out-of-range probe/write addresses can be exercised.

module tb_sc_lane_shift_bank;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        clr_n = 1'b1, ld_n = 1'b1, wr_n = 1'b1, cfg_n = 1'b1;
   logic [1:0]  lvl = '0;
   logic [2:0]  lane = '0;
   logic [7:0]  wdata = '0;
   logic [7:0]  per = '0;
   logic        dir = 1'b0;
   logic        pause = 1'b0;
   logic [2:0]  plane = '0;
   logic [3:0]  pcol = '0;
   logic [31:0] dout;
   logic [3:0]  strobe;
   logic        probe;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   sc_lane_shift_bank #(
      .DATAWIDTH(8), .LANES(4), .LANE_IDX_W(3), .COL_W(4), .PRESCALE_W(8)
   ) dut (
      .SC_RegBACKGTYPE_CLOCK_50     (clk),
      .SC_RegBACKGTYPE_RESET_InHigh (rst),
      .SC_RegBACKGTYPE_clear_InLow  (clr_n),
      .SC_RegBACKGTYPE_load_InLow   (ld_n),
      .SC_RegBACKGTYPE_level_In     (lvl),
      .SC_RegBACKGTYPE_write_InLow  (wr_n),
      .SC_RegBACKGTYPE_lane_In      (lane),
      .SC_RegBACKGTYPE_data_InBUS   (wdata),
      .SC_RegBACKGTYPE_cfg_InLow    (cfg_n),
      .SC_RegBACKGTYPE_period_InBUS (per),
      .SC_RegBACKGTYPE_dir_In       (dir),
      .SC_RegBACKGTYPE_pause_InHigh (pause),
      .SC_RegBACKGTYPE_probeLane_In (plane),
      .SC_RegBACKGTYPE_probeCol_In  (pcol),
      .SC_RegBACKGTYPE_data_OutBUS  (dout),
      .SC_RegBACKGTYPE_strobe_OutBUS(strobe),
      .SC_RegBACKGTYPE_probe_Out    (probe)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick_clk();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      clr_n = 1'b1; ld_n = 1'b1; wr_n = 1'b1; cfg_n = 1'b1;
      lvl = '0; lane = '0; wdata = '0; per = '0; dir = 1'b0;
   endtask

   // ---------------- directed table ----------------
   localparam int OP_IDLE  = 0;
   localparam int OP_LOAD  = 1;   // lane arg is the level
   localparam int OP_CFG   = 2;
   localparam int OP_WRCFG = 3;
   localparam int OP_CLW   = 4;   // clear + load + write together

   typedef struct {
      logic        clr_n, ld_n, wr_n, cfg_n, dir;
      logic [1:0]  lvl;
      logic [2:0]  lane, plane;
      logic [3:0]  pcol;
      logic [7:0]  wdata, per;
      logic [31:0] exp_data;
      logic [3:0]  exp_strobe;
      logic        exp_probe;
   } vec_t;

   function automatic vec_t mk(input int op, input int ln, input int d, input int p,
                               input int dr, input int pl, input int pc,
                               input logic [31:0] ed, input int es, input int ep);
      vec_t v;
      v.clr_n = !(op == OP_CLW);
      v.ld_n  = !(op == OP_LOAD || op == OP_CLW);
      v.wr_n  = !(op == OP_WRCFG || op == OP_CLW);
      v.cfg_n = !(op == OP_CFG || op == OP_WRCFG);
      v.lvl   = (op == OP_LOAD) ? 2'(ln) : 2'd0;
      v.lane  = (op == OP_LOAD) ? 3'd0 : 3'(ln);
      v.wdata = 8'(d);
      v.per   = 8'(p);
      v.dir   = 1'(dr);
      v.plane = 3'(pl);
      v.pcol  = 4'(pc);
      v.exp_data   = ed;
      v.exp_strobe = 4'(es);
      v.exp_probe  = 1'(ep);
      return v;
   endfunction

   vec_t tbl [22];

   // ---------------- reference model ----------------
   logic [7:0] level_pat [4] = '{8'h18, 8'h3C, 8'h81, 8'h0F};
   int   m_lane [4];
   int   m_per  [4];
   int   m_dir  [4];
   int   m_el   [4];   // clocks counted since the lane last moved or restarted
   logic [3:0] m_stb;

   task automatic model_reset();
      for (int k = 0; k < 4; k++) begin
         m_lane[k] = 0; m_per[k] = 0; m_dir[k] = 0; m_el[k] = 0;
      end
      m_stb = '0;
   endtask

   task automatic model_step();
      bit wr, cf, restart, sh;
      for (int k = 0; k < 4; k++) begin
         wr = !wr_n && (int'(lane) == k);
         cf = !cfg_n && (int'(lane) == k);
         restart = !clr_n || !ld_n || wr || cf;
         sh = 1'b0;
         if (restart)
            m_el[k] = 0;
         else if (!pause && m_per[k] != 0) begin
            m_el[k]++;
            if (m_el[k] >= m_per[k]) begin
               sh = 1'b1;
               m_el[k] = 0;
            end
         end
         if (!clr_n)      m_lane[k] = 0;
         else if (!ld_n)  m_lane[k] = int'(level_pat[lvl]);
         else if (wr)     m_lane[k] = int'(wdata);
         else if (sh)     m_lane[k] = (m_dir[k] != 0)
                                      ? ((m_lane[k] >> 1) | ((m_lane[k] & 1) << 7))
                                      : (((m_lane[k] << 1) & 255) | (m_lane[k] >> 7));
         m_stb[k] = sh;
         if (cf) begin
            m_per[k] = int'(per);
            m_dir[k] = int'(dir);
         end
      end
   endtask

   function automatic logic [31:0] model_bus();
      logic [31:0] b;
      for (int k = 0; k < 4; k++) b[k*8 +: 8] = 8'(m_lane[k]);
      return b;
   endfunction

   function automatic logic model_probe();
      if (plane >= 3'd4 || pcol >= 4'd8) return 1'b0;
      return 1'((m_lane[plane] >> pcol) & 1);
   endfunction

   initial begin
      tbl[0]  = mk(OP_LOAD,  1, 0,     0, 0, 1, 2, 32'h3C3C3C3C, 0, 1);
      tbl[1]  = mk(OP_IDLE,  0, 0,     0, 0, 1, 0, 32'h3C3C3C3C, 0, 0);
      tbl[2]  = mk(OP_IDLE,  0, 0,     0, 0, 5, 2, 32'h3C3C3C3C, 0, 0);
      tbl[3]  = mk(OP_IDLE,  0, 0,     0, 0, 1, 9, 32'h3C3C3C3C, 0, 0);
      tbl[4]  = mk(OP_LOAD,  0, 0,     0, 0, 0, 3, 32'h18181818, 0, 1);
      tbl[5]  = mk(OP_CFG,   2, 0,     3, 0, 2, 4, 32'h18181818, 0, 1);
      tbl[6]  = mk(OP_IDLE,  0, 0,     0, 0, 2, 4, 32'h18181818, 0, 1);
      tbl[7]  = mk(OP_IDLE,  0, 0,     0, 0, 2, 4, 32'h18181818, 0, 1);
      tbl[8]  = mk(OP_IDLE,  0, 0,     0, 0, 2, 5, 32'h18301818, 4, 1);
      tbl[9]  = mk(OP_IDLE,  0, 0,     0, 0, 2, 5, 32'h18301818, 0, 1);
      tbl[10] = mk(OP_IDLE,  0, 0,     0, 0, 2, 5, 32'h18301818, 0, 1);
      tbl[11] = mk(OP_IDLE,  0, 0,     0, 0, 2, 6, 32'h18601818, 4, 1);
      tbl[12] = mk(OP_WRCFG, 0, 8'h81, 1, 1, 0, 7, 32'h18601881, 0, 1);
      tbl[13] = mk(OP_IDLE,  0, 0,     0, 0, 0, 7, 32'h186018C0, 1, 1);
      tbl[14] = mk(OP_IDLE,  0, 0,     0, 0, 0, 7, 32'h18C01860, 5, 0);
      tbl[15] = mk(OP_IDLE,  0, 0,     0, 0, 0, 7, 32'h18C01830, 1, 0);
      tbl[16] = mk(OP_CLW,   0, 8'hFF, 0, 0, 0, 7, 32'h00000000, 0, 0);
      tbl[17] = mk(OP_IDLE,  0, 0,     0, 0, 0, 7, 32'h00000000, 1, 0);
      tbl[18] = mk(OP_LOAD,  3, 0,     0, 0, 0, 0, 32'h0F0F0F0F, 0, 1);
      tbl[19] = mk(OP_IDLE,  0, 0,     0, 0, 0, 7, 32'h0F0F0F87, 1, 1);
      tbl[20] = mk(OP_WRCFG, 5, 8'hAA, 1, 0, 0, 7, 32'h0F0F0FC3, 1, 1);
      tbl[21] = mk(OP_IDLE,  0, 0,     0, 0, 2, 4, 32'h0F1E0FE1, 5, 1);

      // reset state
      idle_inputs();
      repeat (3) tick_clk();
      chk("reset_data", dout, 32'h0);
      chk("reset_strobe", {28'h0, strobe}, 32'h0);
      chk("reset_probe", {31'h0, probe}, 32'h0);
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick_clk();
         chk("idle_data", dout, 32'h0);
         chk("idle_strobe", {28'h0, strobe}, 32'h0);
      end

      for (int i = 0; i < 22; i++) begin
         clr_n = tbl[i].clr_n; ld_n = tbl[i].ld_n; wr_n = tbl[i].wr_n; cfg_n = tbl[i].cfg_n;
         lvl = tbl[i].lvl; lane = tbl[i].lane; wdata = tbl[i].wdata; per = tbl[i].per;
         dir = tbl[i].dir; plane = tbl[i].plane; pcol = tbl[i].pcol;
         tick_clk();
         chk($sformatf("tbl%0d_data", i), dout, tbl[i].exp_data);
         chk($sformatf("tbl%0d_strobe", i), {28'h0, strobe}, {28'h0, tbl[i].exp_strobe});
         chk($sformatf("tbl%0d_probe", i), {31'h0, probe}, {31'h0, tbl[i].exp_probe});
      end
      idle_inputs();

      // pause: lane3 period 4, paused after two counts, shifts two cycles after release
      wr_n = 1'b0; cfg_n = 1'b0; lane = 3'd3; wdata = 8'h01; per = 8'd4; dir = 1'b0;
      plane = 3'd3; pcol = 4'd1;
      tick_clk();
      idle_inputs();
      chk("pause_wr_lane3", {24'h0, dout[31:24]}, 32'h01);
      repeat (2) tick_clk();
      pause = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick_clk();
         chk("paused_lane3", {24'h0, dout[31:24]}, 32'h01);
         chk("paused_strobe3", {31'h0, strobe[3]}, 32'h0);
      end
      pause = 1'b0;
      tick_clk();
      chk("resume1_lane3", {24'h0, dout[31:24]}, 32'h01);
      chk("resume1_strobe3", {31'h0, strobe[3]}, 32'h0);
      tick_clk();
      chk("resume2_lane3", {24'h0, dout[31:24]}, 32'h02);
      chk("resume2_strobe3", {31'h0, strobe[3]}, 32'h1);
      chk("resume2_probe", {31'h0, probe}, 32'h1);

      // asynchronous reset mid-period, checked before the next rising edge
      #3 rst = 1'b1;
      #1;
      chk("async_rst_data", dout, 32'h0);
      chk("async_rst_strobe", {28'h0, strobe}, 32'h0);
      chk("async_rst_probe", {31'h0, probe}, 32'h0);
      tick_clk();
      rst = 1'b0;
      model_reset();

      // randomized traffic against the reference model
      for (int i = 0; i < 400; i++) begin
         clr_n = ($urandom_range(19) != 0);
         ld_n  = ($urandom_range(14) != 0);
         wr_n  = ($urandom_range(4) != 0);
         cfg_n = ($urandom_range(5) != 0);
         lvl   = 2'($urandom_range(3));
         lane  = 3'($urandom_range(5));
         wdata = 8'($urandom);
         per   = 8'($urandom_range(4));
         dir   = 1'($urandom_range(1));
         pause = ($urandom_range(7) == 0);
         plane = 3'($urandom_range(5));
         pcol  = 4'($urandom_range(9));
         model_step();
         tick_clk();
         chk("rand_data", dout, model_bus());
         chk("rand_strobe", {28'h0, strobe}, {28'h0, m_stb});
         chk("rand_probe", {31'h0, probe}, {31'h0, model_probe()});
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
